// File: rtl/plab5_mcore_mem_acc_tracked.sv
// Level-checked memory gate: allowed requests pass combinationally, denied ones get a local reply next cycle,
// and responses return in acceptance order. Backpressure: net_req_rdy drops when tracking is full or draining.
module plab5_mcore_mem_acc_tracked #(
    parameter int p_opaque_nbits = 8,
    parameter int p_addr_nbits   = 32,
    parameter int p_data_nbits   = 32,
    parameter int p_level_nbits  = 2,
    parameter int p_num_pending  = 4,
    localparam int c_len_nbits   = $clog2(p_data_nbits / 8),
    localparam int c_req_nbits   = 3 + p_opaque_nbits + p_addr_nbits + c_len_nbits + p_data_nbits,
    localparam int c_resp_nbits  = 3 + p_opaque_nbits + c_len_nbits + p_data_nbits
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [p_level_nbits-1:0]  mem_sec_level,
    input  logic [p_level_nbits-1:0]  req_sec_level,
    input  logic [c_req_nbits-1:0]    net_req_msg,
    input  logic                      net_req_val,
    output logic                      net_req_rdy,
    output logic [c_req_nbits-1:0]    mem_req_msg,
    output logic                      mem_req_val,
    input  logic                      mem_req_rdy,
    input  logic [c_resp_nbits-1:0]   mem_resp_msg,
    input  logic                      mem_resp_val,
    output logic                      mem_resp_rdy,
    output logic [c_resp_nbits-1:0]   net_resp_msg,
    output logic                      net_resp_val,
    input  logic                      net_resp_rdy,
    output logic [p_level_nbits-1:0]  resp_sec_level,
    output logic                      viol_pulse,
    output logic [15:0]               viol_count
);

    localparam int c_ptr_nbits = $clog2(p_num_pending);
    localparam logic [c_ptr_nbits:0] c_full = (c_ptr_nbits + 1)'(p_num_pending);

    typedef enum logic {ST_RUN, ST_DRAIN} state_t;

    state_t                     state_q, state_d;
    logic [p_level_nbits-1:0]   lvl_q;
    logic [c_ptr_nbits-1:0]     wr_ptr_q, rd_ptr_q;
    logic [c_ptr_nbits:0]       count_q;

    logic                       ent_denied [p_num_pending];
    logic [p_level_nbits-1:0]   ent_level  [p_num_pending];
    logic [2:0]                 ent_type   [p_num_pending];
    logic [p_opaque_nbits-1:0]  ent_opaque [p_num_pending];

    logic [2:0]                 req_type;
    logic [p_opaque_nbits-1:0]  req_opaque;
    logic                       req_allowed, fifo_empty, fifo_full;
    logic                       accept_ok, resp_ok, push, pop;

    assign req_type    = net_req_msg[c_req_nbits-1 -: 3];
    assign req_opaque  = net_req_msg[c_req_nbits-4 -: p_opaque_nbits];
    assign req_allowed = (req_sec_level >= lvl_q);
    assign fifo_empty  = (count_q == '0);
    assign fifo_full   = (count_q == c_full);

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_RUN;
        else       state_q <= state_d;
    end

    // A level change only takes effect once every in-flight access has answered.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (mem_sec_level != lvl_q) state_d = ST_DRAIN;
            ST_DRAIN: if (fifo_empty)             state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    always_comb begin
        accept_ok    = (state_q == ST_RUN) && !reset && !fifo_full;
        mem_req_msg  = net_req_msg;
        mem_req_val  = accept_ok && req_allowed && net_req_val;
        net_req_rdy  = accept_ok && (req_allowed ? mem_req_rdy : 1'b1);
        push         = net_req_val && net_req_rdy;

        resp_ok      = !reset && !fifo_empty;
        net_resp_val = resp_ok && (ent_denied[rd_ptr_q] || mem_resp_val);
        mem_resp_rdy = resp_ok && !ent_denied[rd_ptr_q] && net_resp_rdy;
        net_resp_msg = mem_resp_msg;
        if (ent_denied[rd_ptr_q])
            net_resp_msg = {ent_type[rd_ptr_q], ent_opaque[rd_ptr_q],
                            {c_len_nbits{1'b0}}, {p_data_nbits{1'b0}}};
        resp_sec_level = fifo_empty ? '0 : ent_level[rd_ptr_q];
        pop          = net_resp_val && net_resp_rdy;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ent_denied[wr_ptr_q] <= !req_allowed;
            ent_level[wr_ptr_q]  <= req_sec_level;
            ent_type[wr_ptr_q]   <= req_type;
            ent_opaque[wr_ptr_q] <= req_opaque;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lvl_q      <= mem_sec_level;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            viol_pulse <= 1'b0;
            viol_count <= 16'h0;
        end else begin
            if (state_q == ST_DRAIN && state_d == ST_RUN) lvl_q <= mem_sec_level;
            if (push) wr_ptr_q <= wr_ptr_q + c_ptr_nbits'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + c_ptr_nbits'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (c_ptr_nbits + 1)'(1);
                2'b01:   count_q <= count_q - (c_ptr_nbits + 1)'(1);
                default: count_q <= count_q;
            endcase
            viol_pulse <= push && !req_allowed;
            if (push && !req_allowed && viol_count != 16'hFFFF)
                viol_count <= viol_count + 16'd1;
        end
    end

endmodule
